pico_axil_mem_bridge: RTL and testbench

AXI4-Lite slave that fronts the PicoRV32 on-chip 32-bit x 4096-word single-port RAM and drives its Avalon-MM slave port directly (address, byteenable, chipselect, write, writedata, clken, reset_req, readdata). It serialises AXI-Lite writes and reads into single RAM accesses and absorbs the RAM's fixed read latency. It sits between the AXI-Lite interconnect and the RAM.

---
 rtl/pico_axil_pkg.sv | 6 +
 rtl/axil_chan_hold.sv | 30 +++
 rtl/pico_axil_mem_bridge.sv | 143 ++++++++++++++
 tb/tb_pico_axil_mem_bridge.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pico_axil_pkg.sv
// pico_axil_pkg: AXI-Lite response codes and bridge FSM states
package pico_axil_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_BRESP, ST_RD, ST_RLAT, ST_RRESP} state_t;
endpackage

// File: rtl/axil_chan_hold.sv
// axil_chan_hold: one-entry AXI-Lite channel capture register with full flag
module axil_chan_hold #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   input  logic         i_clear
);
   logic         r_full;
   logic [W-1:0] r_data;
   assign o_ready = !r_full && !reset;
   assign o_full  = r_full;
   assign o_data  = r_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_valid && o_ready) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end
endmodule

// File: rtl/pico_axil_mem_bridge.sv
// pico_axil_mem_bridge: AXI4-Lite slave serialising accesses onto the single-port RAM's Avalon-MM port
module pico_axil_mem_bridge
   import pico_axil_pkg::*;
#(
   parameter int AXI_AW     = 32,
   parameter int MEM_AW     = 12,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AXI_AW-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [AXI_AW-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [MEM_AW-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic              avm_clken,
   output logic              avm_reset_req,
   input  logic [31:0]       avm_readdata
);
   localparam int CW = $clog2(RD_LATENCY + 1);
   state_t            r_state;
   logic              r_prio_rd, r_cs, r_we, r_oor, r_bvalid, r_rvalid;
   logic [1:0]        r_bresp, r_rresp;
   logic [31:0]       r_rdata, r_wdata;
   logic [3:0]        r_strb;
   logic [MEM_AW-1:0] r_addr;
   logic [CW-1:0]     r_cnt;
   logic              w_aw_full, w_w_full, w_ar_full, w_wr_rdy, w_tie, w_go_wr, w_go_rd;
   logic              w_aw_oor, w_ar_oor, w_unused;
   logic [AXI_AW-1:0] w_aw_q, w_ar_q;
   logic [35:0]       w_w_q;
   axil_chan_hold #(.W(AXI_AW)) u_aw (.clk(clk), .reset(reset), .i_valid(s_awvalid), .o_ready(s_awready),
      .i_data(s_awaddr), .o_data(w_aw_q), .o_full(w_aw_full), .i_clear(r_state == ST_WR));
   axil_chan_hold #(.W(36)) u_w (.clk(clk), .reset(reset), .i_valid(s_wvalid), .o_ready(s_wready),
      .i_data({s_wstrb, s_wdata}), .o_data(w_w_q), .o_full(w_w_full), .i_clear(r_state == ST_WR));
   axil_chan_hold #(.W(AXI_AW)) u_ar (.clk(clk), .reset(reset), .i_valid(s_arvalid), .o_ready(s_arready),
      .i_data(s_araddr), .o_data(w_ar_q), .o_full(w_ar_full), .i_clear(r_state == ST_RD));
   assign w_wr_rdy = w_aw_full && w_w_full;
   assign w_tie    = w_wr_rdy && w_ar_full;
   assign w_go_wr  = (r_state == ST_IDLE) && w_wr_rdy && !(w_tie && r_prio_rd);
   assign w_go_rd  = (r_state == ST_IDLE) && w_ar_full && !w_go_wr;
   assign w_aw_oor = |w_aw_q[AXI_AW-1:MEM_AW+2];
   assign w_ar_oor = |w_ar_q[AXI_AW-1:MEM_AW+2];
   assign w_unused = ^{w_aw_q[1:0], w_ar_q[1:0]};
   assign s_bresp        = r_bresp;
   assign s_bvalid       = r_bvalid && !reset;
   assign s_rdata        = r_rdata;
   assign s_rresp        = r_rresp;
   assign s_rvalid       = r_rvalid && !reset;
   assign avm_address    = r_addr;
   assign avm_byteenable = (r_state == ST_WR) ? r_strb : 4'hF;
   assign avm_chipselect = r_cs && !reset;
   assign avm_write      = r_we && !reset;
   assign avm_writedata  = r_wdata;
   assign avm_clken      = 1'b1;
   assign avm_reset_req  = reset;
   // Strobes are registered, so gating with reset keeps the reset cycle free of RAM writes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_prio_rd <= 1'b0;
         r_cs      <= 1'b0;
         r_we      <= 1'b0;
         r_oor     <= 1'b0;
         r_bvalid  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_addr    <= '0;
         r_cnt     <= '0;
      end else begin
         r_cs <= 1'b0;
         r_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_tie) r_prio_rd <= !r_prio_rd;
               if (w_go_wr) begin
                  r_state <= ST_WR;
                  r_addr  <= w_aw_q[MEM_AW+1:2];
                  r_oor   <= w_aw_oor;
                  r_wdata <= w_w_q[31:0];
                  r_strb  <= w_w_q[35:32];
                  r_cs    <= !w_aw_oor;
                  r_we    <= !w_aw_oor;
               end else if (w_go_rd) begin
                  r_state <= ST_RD;
                  r_addr  <= w_ar_q[MEM_AW+1:2];
                  r_oor   <= w_ar_oor;
                  r_cs    <= !w_ar_oor;
               end
            end
            ST_WR: begin
               r_state  <= ST_BRESP;
               r_bvalid <= 1'b1;
               r_bresp  <= r_oor ? RESP_SLVERR : RESP_OKAY;
            end
            ST_BRESP: if (s_bready) begin
               r_state  <= ST_IDLE;
               r_bvalid <= 1'b0;
            end
            ST_RD: begin
               r_state <= ST_RLAT;
               r_cnt   <= CW'(RD_LATENCY);
            end
            ST_RLAT: begin
               if (r_cnt == CW'(1)) begin
                  r_state  <= ST_RRESP;
                  r_rvalid <= 1'b1;
                  r_rdata  <= r_oor ? 32'h0 : avm_readdata;
                  r_rresp  <= r_oor ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RRESP: if (s_rready) begin
               r_state  <= ST_IDLE;
               r_rvalid <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pico_axil_mem_bridge.sv
// tb_pico_axil_mem_bridge: directed self-checking bench with a 1-cycle-latency RAM model
`timescale 1ns/1ps
module tb_pico_axil_mem_bridge;
   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata, avm_writedata, avm_readdata;
   logic [3:0]  s_wstrb = '0, avm_byteenable;
   logic        s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 0, s_rready = 0;
   logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [11:0] avm_address;
   logic        avm_chipselect, avm_write, avm_clken, avm_reset_req;
   logic [31:0] mem [4096] = '{default: '0};
   logic [31:0] ram_q = '0;
   logic [12:0] ops [$];
   logic [3:0]  last_be = '0;
   logic [31:0] last_rdata = '0, rd;
   logic [1:0]  resp;
   int          lat, checks = 0, failures = 0;
   always #5 clk = ~clk;
   assign avm_readdata = ram_q;
   pico_axil_mem_bridge dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
      .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_clken(avm_clken),
      .avm_reset_req(avm_reset_req), .avm_readdata(avm_readdata)
   );
   always @(posedge clk) begin
      if (avm_chipselect) begin
         ops.push_back({avm_write, avm_address});
         last_be = avm_byteenable;
         if (avm_write) begin
            for (int b = 0; b < 4; b++)
               if (avm_byteenable[b]) mem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
         end else begin
            ram_q <= mem[avm_address];
         end
      end
      if (s_rvalid && s_rready) last_rdata = s_rdata;
   end
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output int l);
      int t = 0;
      s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1;
      while (!(s_awready && s_wready) && t < 50) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      s_awvalid = 0; s_wvalid = 0;
      l = 1;
      while (!s_bvalid && l < 50) begin @(posedge clk); #1; l++; end
      r = s_bresp;
      s_bready = 1; @(posedge clk); #1; s_bready = 0;
   endtask
   task automatic do_read(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] r, output int l);
      int t = 0;
      s_araddr = a; s_arvalid = 1;
      while (!s_arready && t < 50) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      s_arvalid = 0;
      l = 1;
      while (!s_rvalid && l < 50) begin @(posedge clk); #1; l++; end
      dat = s_rdata; r = s_rresp;
      s_rready = 1; @(posedge clk); #1; s_rready = 0;
   endtask
   task automatic test_reset();
      repeat (3) @(posedge clk); #1;
      checks++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", {s_awready, s_wready, s_arready}); end
      checks++; if ({s_bvalid, s_rvalid, avm_chipselect, avm_write} !== 4'b0) begin failures++; $display("FAIL rst_valids got=%b exp=0000", {s_bvalid, s_rvalid, avm_chipselect, avm_write}); end
      checks++; if ({s_rdata, s_bresp, s_rresp, avm_address} !== 48'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {s_rdata, s_bresp, s_rresp, avm_address}); end
      checks++; if ({avm_clken, avm_reset_req} !== 2'b11) begin failures++; $display("FAIL rst_clken_req got=%b exp=11", {avm_clken, avm_reset_req}); end
      reset = 0; #1;
      checks++; if ({s_awready, s_wready, s_arready, avm_reset_req} !== 4'b1110) begin failures++; $display("FAIL post_rst got=%b exp=1110", {s_awready, s_wready, s_arready, avm_reset_req}); end
   endtask
   task automatic test_write_read();
      int n0 = ops.size();
      do_write(32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      checks++; if (resp !== 2'b00) begin failures++; $display("FAIL wr_bresp got=%b exp=00", resp); end
      checks++; if (ops[n0] !== {1'b1, 12'd4} || last_be !== 4'hF) begin failures++; $display("FAIL wr_avm got=%h be=%h exp=1004 be=f", ops[n0], last_be); end
      do_read(32'h10, rd, resp, lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL rd_latency got=%0d exp=4", lat); end
      checks++; if (rd !== 32'hDEADBEEF || resp !== 2'b00) begin failures++; $display("FAIL rd_data got=%h/%b exp=deadbeef/00", rd, resp); end
      checks++; if (ops[n0+1] !== {1'b0, 12'd4}) begin failures++; $display("FAIL rd_avm got=%h exp=0004", ops[n0+1]); end
   endtask
   task automatic test_strobe();
      do_write(32'h10, 32'h00001234, 4'h3, resp, lat);
      checks++; if (last_be !== 4'h3) begin failures++; $display("FAIL strb_be got=%h exp=3", last_be); end
      do_read(32'h10, rd, resp, lat);
      checks++; if (rd !== 32'hDEAD1234) begin failures++; $display("FAIL strb_readback got=%h exp=dead1234", rd); end
   endtask
   task automatic test_aw_w_skew();
      int n0 = ops.size();
      s_awaddr = 32'h20; s_awvalid = 1;
      @(posedge clk); #1; s_awvalid = 0;
      checks++; if (s_awready !== 1'b0 || s_wready !== 1'b1) begin failures++; $display("FAIL skew_ready got=%b%b exp=01", s_awready, s_wready); end
      repeat (4) @(posedge clk); #1;
      s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1;
      @(posedge clk); #1; s_wvalid = 0;
      checks++; if (avm_chipselect !== 1'b0 || ops.size() !== n0) begin failures++; $display("FAIL skew_early_cs got=%b n=%0d exp=0 n=%0d", avm_chipselect, ops.size(), n0); end
      @(posedge clk); #1;
      checks++; if ({avm_chipselect, avm_write, avm_address} !== {2'b11, 12'h008}) begin failures++; $display("FAIL skew_wr got=%h exp=3008", {avm_chipselect, avm_write, avm_address}); end
      @(posedge clk); #1;
      checks++; if (s_bvalid !== 1'b1) begin failures++; $display("FAIL skew_bvalid got=%b exp=1", s_bvalid); end
      s_bready = 1; @(posedge clk); #1; s_bready = 0;
   endtask
   task automatic test_tie();
      int n0;
      reset = 1; repeat (2) @(posedge clk); #1; reset = 0;
      n0 = ops.size();
      s_awaddr = 32'h40; s_wdata = 32'h11111111; s_wstrb = 4'hF; s_araddr = 32'h40;
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
      @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      repeat (12) @(posedge clk); #1;
      checks++; if (ops.size() !== n0 + 2 || ops[n0] !== {1'b1, 12'h010} || ops[n0+1] !== {1'b0, 12'h010}) begin failures++; $display("FAIL tie1_order got=%h,%h exp=1010,0010", ops[n0], ops[n0+1]); end
      checks++; if (last_rdata !== 32'h11111111) begin failures++; $display("FAIL tie1_rdata got=%h exp=11111111", last_rdata); end
      s_wdata = 32'h22222222; s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
      @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      repeat (12) @(posedge clk); #1;
      checks++; if (ops.size() !== n0 + 4 || ops[n0+2] !== {1'b0, 12'h010} || ops[n0+3] !== {1'b1, 12'h010}) begin failures++; $display("FAIL tie2_order got=%h,%h exp=0010,1010", ops[n0+2], ops[n0+3]); end
      checks++; if (last_rdata !== 32'h11111111) begin failures++; $display("FAIL tie2_rdata got=%h exp=11111111", last_rdata); end
      s_bready = 0; s_rready = 0;
   endtask
   task automatic test_out_of_range();
      int n0 = ops.size();
      do_read(32'h0001_0000, rd, resp, lat);
      checks++; if (rd !== 32'h0 || resp !== 2'b10 || lat !== 4) begin failures++; $display("FAIL oor_rd got=%h/%b/%0d exp=0/10/4", rd, resp, lat); end
      do_write(32'h0001_0010, 32'h5555AAAA, 4'hF, resp, lat);
      checks++; if (resp !== 2'b10 || lat !== 3) begin failures++; $display("FAIL oor_wr got=%b/%0d exp=10/3", resp, lat); end
      checks++; if (ops.size() !== n0) begin failures++; $display("FAIL oor_cs got=%0d exp=%0d", ops.size(), n0); end
   endtask
   task automatic test_backpressure();
      int n0 = ops.size();
      logic held = 1'b1;
      s_awaddr = 32'h60; s_wdata = 32'h60606060; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
      @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0;
      repeat (2) @(posedge clk); #1;
      s_awaddr = 32'h80; s_wdata = 32'h80808080; s_awvalid = 1; s_wvalid = 1;
      @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0;
      checks++; if (s_awready !== 1'b0 || s_wready !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b%b exp=00", s_awready, s_wready); end
      for (int i = 0; i < 9; i++) begin
         if (!s_bvalid || ops.size() != n0 + 1) held = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b n=%0d exp=1 n=%0d", held, ops.size(), n0 + 1); end
      s_bready = 1; repeat (6) @(posedge clk); #1; s_bready = 0;
      checks++; if (ops.size() !== n0 + 2 || ops[n0+1] !== {1'b1, 12'h020}) begin failures++; $display("FAIL bp_second got=%h n=%0d exp=1020", ops[n0+1], ops.size()); end
   endtask
   task automatic test_reset_mid();
      int n0;
      s_awaddr = 32'h10; s_wdata = 32'hBAD0BAD0; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
      @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0;
      @(posedge clk); #1; reset = 1; #1;
      checks++; if ({avm_chipselect, avm_write} !== 2'b00) begin failures++; $display("FAIL rst_wr_strobe got=%b exp=00", {avm_chipselect, avm_write}); end
      @(posedge clk); #1; reset = 0;
      repeat (4) @(posedge clk); #1;
      checks++; if (s_bvalid !== 1'b0) begin failures++; $display("FAIL rst_wr_bvalid got=%b exp=0", s_bvalid); end
      s_araddr = 32'h10; s_arvalid = 1;
      @(posedge clk); #1; s_arvalid = 0;
      repeat (2) @(posedge clk); #1; reset = 1; #1;
      checks++; if ({s_awready, s_wready, s_arready, s_rvalid} !== 4'b0) begin failures++; $display("FAIL rst_rlat_outs got=%b exp=0000", {s_awready, s_wready, s_arready, s_rvalid}); end
      @(posedge clk); #1; reset = 0; n0 = ops.size();
      repeat (6) @(posedge clk); #1;
      checks++; if (s_rvalid !== 1'b0 || ops.size() !== n0) begin failures++; $display("FAIL rst_rlat_idle got=%b n=%0d exp=0 n=%0d", s_rvalid, ops.size(), n0); end
      do_read(32'h10, rd, resp, lat);
      checks++; if (rd !== 32'hDEAD1234 || lat !== 4) begin failures++; $display("FAIL rst_recover got=%h/%0d exp=dead1234/4", rd, lat); end
   endtask
   initial begin
      test_reset();
      test_write_read();
      test_strobe();
      test_aw_w_skew();
      test_tie();
      test_out_of_range();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
